// File: rtl/exe_pkg.sv
// exe_pkg: shared types for the execute/memory boundary.
//   DATA_W / DEST_W : default payload and register-address widths
//   exe_entry_t     : one in-flight EXE->MEM entry (control bits + payload)
//   occ_t           : occupancy of the EXE->MEM skid register
package exe_pkg;

  localparam int DATA_W = 32;
  localparam int DEST_W = 5;

  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] st_val;
    logic [DEST_W-1:0] dest;
  } exe_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/exe_mem_skid_reg.sv
// exe_mem_skid_reg: EXE->MEM pipeline register with a two-entry skid buffer.
//   clk, rst (async, active-low), flush (sync squash)
//   in_valid/in_ready + *_in      : entry from EXE; in_ready is a flop
//   out_valid/out_ready + outputs : head entry toward MEM
//   fwd_en/fwd_dest/fwd_data      : forwarding tap of the head entry
//   count                         : occupancy 0..2
//   stall_cycles                  : saturating count of back-pressured cycles
module exe_mem_skid_reg
  import exe_pkg::*;
#(
  parameter int DATA_W = exe_pkg::DATA_W,
  parameter int DEST_W = exe_pkg::DEST_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] st_val_in,
  input  logic [DEST_W-1:0] dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] st_val,
  output logic [DEST_W-1:0] dest,
  output logic              fwd_en,
  output logic [DEST_W-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_data,
  output logic [1:0]        count,
  output logic [CNT_W-1:0]  stall_cycles
);

  // Same layout as exe_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] st_val;
    logic [DEST_W-1:0] dest;
  } entry_t;

  entry_t           head_reg, skid_reg, in_entry;
  logic             head_vld_reg, skid_vld_reg;
  occ_t             state_reg;
  logic             in_ready_reg;
  logic [1:0]       count_reg;
  logic [CNT_W-1:0] stall_reg;
  logic             acc, pop;

  // Drop the control bits of an entry so a bubble never carries a write.
  function automatic entry_t squash(input entry_t e);
    entry_t r;
    r          = e;
    r.wb_en    = 1'b0;
    r.mem_r_en = 1'b0;
    r.mem_w_en = 1'b0;
    return r;
  endfunction

  assign in_entry = '{wb_en: wb_en_in, mem_r_en: mem_r_en_in, mem_w_en: mem_w_en_in,
                      pc: pc_in, alu_result: alu_result_in, st_val: st_val_in,
                      dest: dest_in};

  assign acc = in_valid & in_ready_reg;
  assign pop = head_vld_reg & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= EMPTY;
      head_reg     <= '0;
      skid_reg     <= '0;
      head_vld_reg <= 1'b0;
      skid_vld_reg <= 1'b0;
      in_ready_reg <= 1'b1;
      count_reg    <= 2'd0;
    end else if (flush) begin
      // Squash wins over any accept/pop this cycle; payload may stay stale.
      state_reg    <= EMPTY;
      head_reg     <= squash(head_reg);
      skid_reg     <= squash(skid_reg);
      head_vld_reg <= 1'b0;
      skid_vld_reg <= 1'b0;
      in_ready_reg <= 1'b1;
      count_reg    <= 2'd0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (acc) begin
            head_reg     <= in_entry;
            head_vld_reg <= 1'b1;
            state_reg    <= ONE;
            count_reg    <= 2'd1;
          end
        end
        ONE: begin
          if (acc && pop) begin
            head_reg <= in_entry;
          end else if (acc) begin
            // MEM stalled: park the new entry, stop accepting next cycle.
            skid_reg     <= in_entry;
            skid_vld_reg <= 1'b1;
            state_reg    <= TWO;
            count_reg    <= 2'd2;
            in_ready_reg <= 1'b0;
          end else if (pop) begin
            head_reg     <= squash(head_reg);
            head_vld_reg <= 1'b0;
            state_reg    <= EMPTY;
            count_reg    <= 2'd0;
          end
        end
        TWO: begin
          if (pop) begin
            head_reg     <= skid_reg;
            skid_reg     <= squash(skid_reg);
            skid_vld_reg <= 1'b0;
            state_reg    <= ONE;
            count_reg    <= 2'd1;
            in_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg    <= EMPTY;
          head_vld_reg <= 1'b0;
          skid_vld_reg <= 1'b0;
          in_ready_reg <= 1'b1;
          count_reg    <= 2'd0;
        end
      endcase
    end
  end

  // Counts MEM back-pressure; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_reg <= '0;
    end else if (head_vld_reg && !out_ready && (stall_reg != '1)) begin
      stall_reg <= stall_reg + CNT_W'(1);
    end
  end

  assign in_ready     = in_ready_reg;
  assign out_valid    = head_vld_reg;
  assign wb_en        = head_reg.wb_en;
  assign mem_r_en     = head_reg.mem_r_en;
  assign mem_w_en     = head_reg.mem_w_en;
  assign pc           = head_reg.pc;
  assign alu_result   = head_reg.alu_result;
  assign st_val       = head_reg.st_val;
  assign dest         = head_reg.dest;
  // Loads get their value from MEM, so they never forward from here.
  assign fwd_en       = head_vld_reg & head_reg.wb_en & ~head_reg.mem_r_en;
  assign fwd_dest     = head_reg.dest;
  assign fwd_data     = head_reg.alu_result;
  assign count        = count_reg;
  assign stall_cycles = stall_reg;

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// tb_exe_mem_skid_reg: table-driven bench for exe_mem_skid_reg.
//   dut  : default widths, 16-bit stall counter
//   dut2 : same stimulus, CNT_W = 2 to observe counter saturation
module tb_exe_mem_skid_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0;
  logic [31:0] pc_in = '0, alu_result_in = '0, st_val_in = '0;
  logic [4:0]  dest_in = '0;

  logic        in_ready, out_valid, wb_en, mem_r_en, mem_w_en, fwd_en;
  logic [31:0] pc, alu_result, st_val, fwd_data;
  logic [4:0]  dest, fwd_dest;
  logic [1:0]  count;
  logic [15:0] stall_cycles;

  logic        d2_in_ready, d2_out_valid, d2_wb_en, d2_mem_r_en, d2_mem_w_en, d2_fwd_en;
  logic [31:0] d2_pc, d2_alu_result, d2_st_val, d2_fwd_data;
  logic [4:0]  d2_dest, d2_fwd_dest;
  logic [1:0]  d2_count;
  logic [1:0]  d2_stall_cycles;

  always #5 clk = ~clk;

  exe_mem_skid_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .pc_in(pc_in), .alu_result_in(alu_result_in), .st_val_in(st_val_in), .dest_in(dest_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .pc(pc), .alu_result(alu_result), .st_val(st_val), .dest(dest),
    .fwd_en(fwd_en), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .count(count), .stall_cycles(stall_cycles)
  );

  exe_mem_skid_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d2_in_ready),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .pc_in(pc_in), .alu_result_in(alu_result_in), .st_val_in(st_val_in), .dest_in(dest_in),
    .out_valid(d2_out_valid), .out_ready(out_ready),
    .wb_en(d2_wb_en), .mem_r_en(d2_mem_r_en), .mem_w_en(d2_mem_w_en),
    .pc(d2_pc), .alu_result(d2_alu_result), .st_val(d2_st_val), .dest(d2_dest),
    .fwd_en(d2_fwd_en), .fwd_dest(d2_fwd_dest), .fwd_data(d2_fwd_data),
    .count(d2_count), .stall_cycles(d2_stall_cycles)
  );

  typedef struct {
    logic        iv, ordy, fl, wb, mr, mw;
    logic [31:0] alu;
    logic [4:0]  dst;
    logic        e_ov, e_ir;
    logic [1:0]  e_cnt;
    logic [31:0] e_alu;
    logic [4:0]  e_dst;
    logic        e_wb, e_mr, e_mw;
    int          e_st;
  } vec_t;

  localparam int NVEC = 21;
  vec_t tbl [NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl, input logic wb,
                       input logic mr, input logic mw, input logic [31:0] alu,
                       input logic [4:0] dst);
    in_valid      = iv;
    out_ready     = ordy;
    flush         = fl;
    wb_en_in      = wb;
    mem_r_en_in   = mr;
    mem_w_en_in   = mw;
    alu_result_in = alu;
    pc_in         = alu + 32'h1000;
    st_val_in     = alu + 32'h2000;
    dest_in       = dst;
  endtask

  initial begin
    //            iv or fl wb mr mw alu    dst   ov ir cnt e_alu  e_dst wb mr mw st
    // streaming
    tbl[0]  = '{1, 1, 0, 1, 0, 0, 32'h10, 5'd10, 1, 1, 1, 32'h10, 5'd10, 1, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 1, 0, 0, 32'h20, 5'd1,  1, 1, 1, 32'h20, 5'd1,  1, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 1, 0, 0, 32'h30, 5'd2,  1, 1, 1, 32'h30, 5'd2,  1, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 0, 0, 32'h0,  5'd0,  0, 1, 0, 32'h0,  5'd0,  0, 0, 0, 0};
    // back-pressure: A, B fill both slots, C refused until a pop
    tbl[4]  = '{1, 0, 0, 0, 0, 1, 32'hA,  5'd3,  1, 1, 1, 32'hA,  5'd3,  0, 0, 1, 0};
    tbl[5]  = '{1, 0, 0, 1, 1, 0, 32'hB,  5'd4,  1, 0, 2, 32'hA,  5'd3,  0, 0, 1, 1};
    tbl[6]  = '{1, 0, 0, 1, 0, 0, 32'hC,  5'd5,  1, 0, 2, 32'hA,  5'd3,  0, 0, 1, 2};
    tbl[7]  = '{1, 1, 0, 1, 0, 0, 32'hC,  5'd5,  1, 1, 1, 32'hB,  5'd4,  1, 1, 0, 2};
    tbl[8]  = '{1, 1, 0, 1, 0, 0, 32'hC,  5'd5,  1, 1, 1, 32'hC,  5'd5,  1, 0, 0, 2};
    tbl[9]  = '{0, 1, 0, 0, 0, 0, 32'h0,  5'd0,  0, 1, 0, 32'h0,  5'd0,  0, 0, 0, 2};
    // flush from TWO with a concurrent offer of 0xFF
    tbl[10] = '{1, 0, 0, 0, 0, 1, 32'h11, 5'd6,  1, 1, 1, 32'h11, 5'd6,  0, 0, 1, 2};
    tbl[11] = '{1, 0, 0, 0, 0, 1, 32'h12, 5'd8,  1, 0, 2, 32'h11, 5'd6,  0, 0, 1, 3};
    tbl[12] = '{1, 0, 1, 1, 0, 1, 32'hFF, 5'd9,  0, 1, 0, 32'h0,  5'd0,  0, 0, 0, 4};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 32'h0,  5'd0,  0, 1, 0, 32'h0,  5'd0,  0, 0, 0, 4};
    // forwarding: ALU op forwards, load does not
    tbl[14] = '{1, 0, 0, 1, 0, 0, 32'h55, 5'd7,  1, 1, 1, 32'h55, 5'd7,  1, 0, 0, 4};
    tbl[15] = '{0, 1, 0, 0, 0, 0, 32'h0,  5'd0,  0, 1, 0, 32'h0,  5'd0,  0, 0, 0, 4};
    tbl[16] = '{1, 1, 0, 1, 1, 0, 32'h66, 5'd7,  1, 1, 1, 32'h66, 5'd7,  1, 1, 0, 4};
    tbl[17] = '{0, 1, 0, 0, 0, 0, 32'h0,  5'd0,  0, 1, 0, 32'h0,  5'd0,  0, 0, 0, 4};
    // flush beats a simultaneous accept+pop in ONE
    tbl[18] = '{1, 0, 0, 1, 0, 1, 32'h77, 5'd1,  1, 1, 1, 32'h77, 5'd1,  1, 0, 1, 4};
    tbl[19] = '{1, 1, 1, 1, 0, 1, 32'h88, 5'd2,  0, 1, 0, 32'h0,  5'd0,  0, 0, 0, 4};
    tbl[20] = '{0, 0, 0, 0, 0, 0, 32'h0,  5'd0,  0, 1, 0, 32'h0,  5'd0,  0, 0, 0, 4};

    // Reset state while rst is held low
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_ctrl", {wb_en, mem_r_en, mem_w_en}, 0);
    chk("rst_payload", {pc, alu_result, st_val}, 0);
    chk("rst_fwd", {fwd_en, fwd_dest, fwd_data}, 0);
    chk("rst_stall", stall_cycles, 0);
    $display("reset: ov=%0b ir=%0b cnt=%0d stall=%0d", out_valid, in_ready, count, stall_cycles);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      vec_t v;
      int   st2;
      v = tbl[i];
      drive(v.iv, v.ordy, v.fl, v.wb, v.mr, v.mw, v.alu, v.dst);
      @(posedge clk);
      #1;
      st2 = (v.e_st > 3) ? 3 : v.e_st;
      $display("vec %0d: ov=%0b ir=%0b cnt=%0d alu=%0h dest=%0d ctrl=%0b%0b%0b fwd=%0b stall=%0d/%0d",
               i, out_valid, in_ready, count, alu_result, dest, wb_en, mem_r_en, mem_w_en,
               fwd_en, stall_cycles, d2_stall_cycles);
      chk($sformatf("v%0d_out_valid", i), out_valid, v.e_ov);
      chk($sformatf("v%0d_in_ready", i), in_ready, v.e_ir);
      chk($sformatf("v%0d_count", i), count, v.e_cnt);
      chk($sformatf("v%0d_ctrl", i), {wb_en, mem_r_en, mem_w_en}, {v.e_wb, v.e_mr, v.e_mw});
      chk($sformatf("v%0d_fwd_en", i), fwd_en, v.e_ov & v.e_wb & ~v.e_mr);
      chk($sformatf("v%0d_stall", i), stall_cycles, v.e_st);
      chk($sformatf("v%0d_stall_sat", i), d2_stall_cycles, st2);
      if (v.e_ov) begin
        chk($sformatf("v%0d_alu", i), alu_result, v.e_alu);
        chk($sformatf("v%0d_pc", i), pc, v.e_alu + 32'h1000);
        chk($sformatf("v%0d_st_val", i), st_val, v.e_alu + 32'h2000);
        chk($sformatf("v%0d_dest", i), dest, v.e_dst);
        chk($sformatf("v%0d_fwd_dest", i), fwd_dest, v.e_dst);
        chk($sformatf("v%0d_fwd_data", i), fwd_data, v.e_alu);
      end
      @(negedge clk);
    end

    // Reset asserted between edges while TWO is full
    drive(1, 0, 0, 1, 0, 1, 32'h21, 5'd3);
    @(posedge clk);
    @(negedge clk);
    drive(1, 0, 0, 1, 0, 1, 32'h22, 5'd4);
    @(posedge clk);
    #1;
    chk("mid_fill_count", count, 2);
    @(negedge clk);
    #2;
    drive(0, 0, 0, 0, 0, 0, 32'h0, 5'd0);
    rst = 1'b0;
    #1;
    $display("mid-reset: ov=%0b ir=%0b cnt=%0d alu=%0h stall=%0d", out_valid, in_ready, count,
             alu_result, stall_cycles);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_ctrl", {wb_en, mem_r_en, mem_w_en, fwd_en}, 0);
    chk("mid_rst_payload", {pc, alu_result, st_val, dest}, 0);
    chk("mid_rst_stall", stall_cycles, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 1, 0, 0, 0, 0, 32'h1, 5'd1);
    @(posedge clk);
    #1;
    $display("post-reset push: ov=%0b alu=%0h cnt=%0d", out_valid, alu_result, count);
    chk("post_rst_out_valid", out_valid, 1);
    chk("post_rst_alu", alu_result, 32'h1);
    chk("post_rst_count", count, 1);

    // Saturation: hold the head with out_ready low for 6 cycles
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 32'h0, 5'd0);
      @(posedge clk);
      #1;
      $display("hold %0d: stall=%0d stall_sat=%0d", k, stall_cycles, d2_stall_cycles);
      chk($sformatf("hold%0d_stall", k), stall_cycles, k);
      chk($sformatf("hold%0d_stall_sat", k), d2_stall_cycles, (k > 3) ? 3 : k);
    end
    chk("hold_count", count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
